// File: rtl/input_conditioner.sv
// Synchronises and debounces five switch pins and the IR pin, with IR rising-edge pulse.
// Optional sticky IR event flag (cleared by ir_ack) when INPUT_IR_STICKY_EN is defined.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sw_raw,
  input  logic       ir_raw,
  input  logic       ir_ack,
  output logic [4:0] sw,
  output logic       IR,
  output logic       ir_pulse
);

  localparam int unsigned N_CH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  stable;
  logic [CNT_W-1:0] cnt [N_CH];
  logic             ir_stable;
  logic             ir_prev;

  // Channel 5 is the IR pin; channels 4:0 are the switches.
  assign raw = {ir_raw, sw_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any cycle of agreement restarts the count; the counter saturates at CNT_MAX by committing.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (reset) begin
        stable[i] <= 1'b0;
        cnt[i]    <= '0;
      end else if (s2[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable[i] <= s2[i];
        cnt[i]    <= '0;
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign sw        = stable[4:0];
  assign ir_stable = stable[5];

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_prev  <= 1'b0;
      ir_pulse <= 1'b0;
    end else begin
      ir_prev  <= ir_stable;
      ir_pulse <= ir_stable & ~ir_prev;
    end
  end

`ifdef INPUT_IR_STICKY_EN
  logic ir_flag;

  // A new event outranks a simultaneous acknowledge so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_flag <= 1'b0;
    end else if (ir_pulse) begin
      ir_flag <= 1'b1;
    end else if (ir_ack) begin
      ir_flag <= 1'b0;
    end
  end

  assign IR = ir_flag;
`else
  logic unused_ir_ack;
  assign unused_ir_ack = ir_ack;
  assign IR            = ir_stable;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES = 4; expectations are
// scheduled by edge number from the documented latencies and checked on the falling edge.
module tb_input_conditioner;

  localparam int unsigned DC  = 4;
  localparam int unsigned KSW = 0;
  localparam int unsigned KIR = 1;
  localparam int unsigned KP  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sw_raw;
  logic       ir_raw;
  logic       ir_ack;
  logic [4:0] sw;
  logic       IR;
  logic       ir_pulse;

  input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .ir_raw   (ir_raw),
    .ir_ack   (ir_ack),
    .sw       (sw),
    .IR       (IR),
    .ir_pulse (ir_pulse)
  );

  always #5 clk = ~clk;

  int unsigned ecount = 0;
  always @(posedge clk) ecount++;

  typedef struct {
    int unsigned cyc;
    int unsigned kind;
    logic [4:0]  val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s edge %0d: got %h expected %h", tag, ecount, obs, expv);
    end
  endtask

  function automatic void push(input int unsigned cyc, input int unsigned kind, input logic [4:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endfunction

  function automatic void push_range(input int unsigned c0, input int unsigned c1,
                                     input int unsigned kind, input logic [4:0] v);
    for (int unsigned c = c0; c <= c1; c++) push(c, kind, v);
  endfunction

  // Outputs settle after the posedge numbered ecount; compare everything due at that edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == ecount) begin
        case (sb[i].kind)
          KSW:     check_eq("sw", sw, sb[i].val);
          KIR:     check_eq("IR", {4'b0, IR}, sb[i].val);
          default: check_eq("ir_pulse", {4'b0, ir_pulse}, sb[i].val);
        endcase
        sb.delete(i);
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Raw change applied before edge k.
  function automatic void exp_sw_step(input int unsigned k, input logic [4:0] o, input logic [4:0] n);
    push_range(k, k + DC, KSW, o);
    push(k + DC + 1, KSW, n);
  endfunction

  function automatic void exp_ir_rise(input int unsigned k);
    push_range(k, k + DC + 1, KP, 5'd0);
    push(k + DC + 2, KP, 5'd1);
    push(k + DC + 3, KP, 5'd0);
`ifdef INPUT_IR_STICKY_EN
    push_range(k, k + DC + 2, KIR, 5'd0);
    push(k + DC + 3, KIR, 5'd1);
`else
    push_range(k, k + DC, KIR, 5'd0);
    push(k + DC + 1, KIR, 5'd1);
`endif
  endfunction

  function automatic void exp_ir_fall(input int unsigned k);
    push_range(k, k + DC + 4, KP, 5'd0);
`ifdef INPUT_IR_STICKY_EN
    push_range(k, k + DC + 4, KIR, 5'd1);
`else
    push_range(k, k + DC, KIR, 5'd1);
    push_range(k + DC + 1, k + DC + 4, KIR, 5'd0);
`endif
  endfunction

  task automatic ack_clear();
    int unsigned k;
    ir_ack = 1'b1;
    k = ecount + 1;
    push(k, KIR, 5'd0);
    push(k + 1, KIR, 5'd0);
    idle(1);
    ir_ack = 1'b0;
    idle(3);
  endtask

  task automatic ir_fall_and_clear();
    ir_raw = 1'b0;
    exp_ir_fall(ecount + 1);
    idle(9);
    ack_clear();
  endtask

  initial begin
    int unsigned k;
    int unsigned r;

    // Reset with all inputs high; they must look like fresh rises after release.
    reset  = 1'b1;
    sw_raw = 5'h1F;
    ir_raw = 1'b1;
    ir_ack = 1'b0;
    push_range(1, 3, KSW, 5'd0);
    push_range(1, 3, KIR, 5'd0);
    push_range(1, 3, KP, 5'd0);
    idle(3);
    reset = 1'b0;
    k = ecount + 1;
    exp_sw_step(k, 5'h00, 5'h1F);
    exp_ir_rise(k);
    idle(10);

    // Falling edges: no pulse; sticky IR holds until acknowledged.
    sw_raw = 5'h00;
    k = ecount + 1;
    exp_sw_step(k, 5'h1F, 5'h00);
    ir_fall_and_clear();

    // Clean step and back.
    sw_raw = 5'h0A;
    exp_sw_step(ecount + 1, 5'h00, 5'h0A);
    idle(8);
    sw_raw = 5'h00;
    exp_sw_step(ecount + 1, 5'h0A, 5'h00);
    idle(8);

    // 3-cycle glitch is rejected.
    sw_raw = 5'h04;
    k = ecount + 1;
    push_range(k, k + 10, KSW, 5'h00);
    idle(3);
    sw_raw = 5'h00;
    idle(10);

    // 3 high, 1 low, 4+ high: only the final run commits.
    sw_raw = 5'h04;
    k = ecount + 1;
    push_range(k, k + 8, KSW, 5'h00);
    push(k + 9, KSW, 5'h04);
    idle(3);
    sw_raw = 5'h00;
    idle(1);
    sw_raw = 5'h04;
    idle(8);
    sw_raw = 5'h00;
    exp_sw_step(ecount + 1, 5'h04, 5'h00);
    idle(8);

    // IR rise with ir_ack on the edge that samples ir_pulse high.
    ir_raw = 1'b1;
    k = ecount + 1;
    exp_ir_rise(k);
    push(k + DC + 4, KIR, 5'd1);
    idle(DC + 3);
    ir_ack = 1'b1;
    idle(1);
    ir_ack = 1'b0;
    idle(4);
    ir_fall_and_clear();

    // Reset mid-debounce discards the partial count.
    ir_raw = 1'b1;
    k = ecount + 1;
    push_range(k, k + 4, KIR, 5'd0);
    push_range(k, k + 4, KP, 5'd0);
    idle(3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    r = ecount + 1;
    exp_ir_rise(r);
    idle(10);
    ir_fall_and_clear();

    for (int unsigned t = 0; t < 50 && sb.size() > 0; t++) idle(1);
    check_eq("sb_drain", (sb.size() > 0) ? 5'd1 : 5'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Input conditioning stage that sits directly upstream of the core's input block. It takes the raw, asynchronous switch pins and the IR sensor pin and synchronises each one into `clk`. It then debounces every bit and presents clean, glitch-free `sw` and `IR` signals to the memory-mapped input path. An IR rising-edge pulse is always produced; optionally, a sticky IR event flag lets software that polls slowly still catch short IR events.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 8. Number of consecutive clock edges a synchronised input must differ from its stable value before the stable value changes. Legal range is 1 to 65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`. Width of each per-bit debounce counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sw_raw`  input  5  raw switch pins, asynchronous.
- `ir_raw`  input  1  raw IR sensor pin, asynchronous.
- `ir_ack`  input  1  one-cycle clear of the sticky IR flag; driven high by the core when it reads the IR address. Used only when the sticky-flag feature is compiled in.
- `sw`  output  5  debounced switch levels, fed to the input block.
- `IR`  output  1  conditioned IR value fed to the input block (see Configuration).
- `ir_pulse`  output  1  one-cycle pulse on each debounced IR rising edge.

## Operation
- Six independent channels: `sw_raw[4:0]` and `ir_raw`. Each channel is identical:
  - Two-flop synchroniser: `s1 <= raw`, `s2 <= s1`.
  - Debounce state: registered `stable` bit plus a `CNT_W`-bit counter `cnt`.
- Debounce rule, evaluated per channel on every edge:
  - If `s2 == stable`: `cnt <= 0`.
  - If `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
- Any single cycle of agreement restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the outputs.
- With `DEBOUNCE_CYCLES = 1`, the block reduces to a pure 2-flop synchroniser with one extra register stage.
- The counter never exceeds `DEBOUNCE_CYCLES-1`; there is no wrap-around.
- `sw = stable[4:0]`.
- IR edge detect:
  - `ir_prev <= ir_stable`.
  - `ir_pulse <= ir_stable & ~ir_prev`, which is registered and high for exactly one cycle.
  - A falling edge produces no pulse.
- Reset clears all synchronisers, stable bits, counters, `ir_prev`, `ir_pulse` and the sticky flag to 0.
  - Reset asserted mid-debounce discards partial counts.
  - Inputs that are already high at reset release are treated as fresh 0→1 transitions.

## Timing
- Reset values: `sw = 5'b00000`, `IR = 0`, `ir_pulse = 0`, from the first edge at which `reset` is sampled high.
- Latency, for a raw input that changes before edge k and then holds steady:
  - `s2` reflects the new value after edge k+1.
  - `stable`, and therefore `sw` / `IR`, changes after edge k+1+`DEBOUNCE_CYCLES`.
  - Total latency is `DEBOUNCE_CYCLES+2` edges.
- `ir_pulse` is high for the single cycle following the edge at which `ir_stable` rises, i.e. `DEBOUNCE_CYCLES+3` edges after the raw change.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: `INPUT_IR_STICKY_EN`.
- Defined:
  - Adds a register `ir_flag`, set on any cycle where `ir_pulse` is high.
  - `ir_flag` is cleared on a cycle where `ir_ack` is high.
  - If set and clear occur together, set wins and the flag stays 1.
  - `IR = ir_flag`.
- Not defined:
  - `ir_flag` is not built and `ir_ack` is ignored.
  - `IR = ir_stable`, the debounced level.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- Reset: hold `reset` high for 3 cycles with `sw_raw = 5'h1F`, `ir_raw = 1` → `sw = 0`, `IR = 0`, `ir_pulse = 0` during reset. After release, `sw = 5'h1F` exactly 6 edges later.
- Clean step: `sw_raw` goes 0→`5'h0A` before edge k → `sw` stays 0 through edge k+4 and becomes `5'h0A` after edge k+5.
- Glitch rejection: `sw_raw[2]` high for 3 cycles then low → `sw[2]` never asserts. A 3-cycle high, 1-cycle low, 4-cycle high pattern asserts `sw[2]` only after the final run completes.
- IR pulse: `ir_raw` 0→1, held → `ir_pulse` high for exactly 1 cycle, 7 edges after the change. Returning `ir_raw` to 0 produces no pulse.
- Sticky flag, with `INPUT_IR_STICKY_EN` defined: IR high for 10 cycles then low → `IR` stays 1 after `ir_raw` is low. `ir_ack` pulse → `IR = 0` on the next cycle. `ir_ack` asserted on the same cycle as `ir_pulse` → `IR` remains 1.
- Reset mid-debounce: `ir_raw` rises, then assert `reset` 3 edges later → no `ir_pulse` and `IR = 0`. After release with `ir_raw` still 1, `ir_pulse` fires 7 edges after release.
